md_unit_ctrl: RTL and testbench

//  Multi-cycle multiply/divide controller with HI/LO for the E stage of the 5-stage pipeline.

---
 rtl/md_unit_ctrl.sv | 127 ++++++++++++
 tb/tb_md_unit_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/md_unit_ctrl.sv
// md_unit_ctrl: multi-cycle multiply/divide controller for the E stage.
// It decodes the E-stage md operation and raises start/busy for the hazard unit.
// The result is computed when the op is accepted and held in temporaries.
// HI/LO are committed only once the fixed busy window ends.
//
// Handshake: start is a combinational accept strobe (md_en & md_op<=3 & !busy).
// The op is taken on the same rising edge that start is high.
// busy is registered and stays high while the unit runs. Any md_en that arrives
// while busy is high is ignored, and the hazard unit is expected to stall it.
module md_unit_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        md_en,
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        start,
  output logic        busy,
  output logic [31:0] md_out,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        dbg_run
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t         state_q;
  logic [CW-1:0]  cnt_q;
  logic [31:0]    tmp_hi_q, tmp_lo_q;
  logic           div0_q;
  logic [31:0]    hi_q, lo_q;

  logic           is_div_d;
  logic           div0_d;
  logic [31:0]    den_d;
  logic [63:0]    mul_s_d, mul_u_d;
  logic [31:0]    quo_s_d, rem_s_d, quo_u_d, rem_u_d;
  logic [31:0]    res_hi_d, res_lo_d;
  logic [CW-1:0]  cnt_init_d;

  assign busy    = (state_q == S_RUN);
  assign dbg_run = (state_q == S_RUN);
  assign start   = md_en & ~md_op[2] & ~busy;
  assign md_out  = (md_op == 3'd4) ? hi_q : lo_q;
  assign hi      = hi_q;
  assign lo      = lo_q;

  assign is_div_d   = md_op[1];
  assign div0_d     = is_div_d & (src_b == 32'd0);
  // A zero divisor is replaced so the divider never sees zero.
  // That result is thrown away anyway.
  assign den_d      = (src_b == 32'd0) ? 32'd1 : src_b;
  assign cnt_init_d = is_div_d ? DIV_N : MULT_N;

  // Arithmetic for all four ops, evaluated from the E-stage operands
  always_comb begin
    mul_s_d = 64'($signed(src_a) * $signed(src_b));
    mul_u_d = {32'd0, src_a} * {32'd0, src_b};
    quo_s_d = 32'($signed(src_a) / $signed(den_d));
    rem_s_d = 32'($signed(src_a) % $signed(den_d));
    quo_u_d = src_a / den_d;
    rem_u_d = src_a % den_d;
  end

  // Select the {hi,lo} pair for the op being started
  always_comb begin
    res_hi_d = 32'd0;
    res_lo_d = 32'd0;
    case (md_op[1:0])
      2'd0: begin res_hi_d = mul_s_d[63:32]; res_lo_d = mul_s_d[31:0]; end
      2'd1: begin res_hi_d = mul_u_d[63:32]; res_lo_d = mul_u_d[31:0]; end
      2'd2: begin res_hi_d = rem_s_d;        res_lo_d = quo_s_d;        end
      default: begin res_hi_d = rem_u_d;     res_lo_d = quo_u_d;        end
    endcase
  end

  // Control FSM, busy-cycle counter, temporaries and the architectural HI/LO
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      tmp_hi_q <= 32'd0;
      tmp_lo_q <= 32'd0;
      div0_q   <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            tmp_hi_q <= res_hi_d;
            tmp_lo_q <= res_lo_d;
            div0_q   <= div0_d;
            cnt_q    <= cnt_init_d;
            state_q  <= S_RUN;
          end else if (md_en && md_op == 3'd6) begin
            hi_q <= src_a;
          end else if (md_en && md_op == 3'd7) begin
            lo_q <= src_a;
          end
        end
        S_RUN: begin
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            // A divide by zero still uses its full busy window but leaves HI/LO alone
            if (!div0_q) begin
              hi_q <= tmp_hi_q;
              lo_q <= tmp_lo_q;
            end
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit_ctrl.sv
// tb_md_unit_ctrl: directed and randomized bench for md_unit_ctrl.
// A timestamp-based reference model predicts start/busy/md_out/hi/lo.
// The outputs are compared against it on every falling edge.
module tb_md_unit_ctrl;
  localparam int MC = 5;
  localparam int DC = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        md_en = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic        start, busy, dbg_run;
  logic [31:0] md_out, hi, lo;

  md_unit_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .md_en(md_en), .md_op(md_op),
    .src_a(src_a), .src_b(src_b), .start(start), .busy(busy),
    .md_out(md_out), .hi(hi), .lo(lo), .dbg_run(dbg_run)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Arithmetic follows the textbook definitions.
  // Signed division works on magnitudes and then restores the signs.
  function automatic void ref_calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] h, output logic [31:0] l);
    longint sa, sb, ma, mb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    h = 32'd0;
    l = 32'd0;
    case (op)
      3'd0: begin p = 64'(sa * sb); h = p[63:32]; l = p[31:0]; end
      3'd1: begin p = {32'd0, a} * {32'd0, b}; h = p[63:32]; l = p[31:0]; end
      3'd2: begin
        ma = (sa < 0) ? -sa : sa;
        mb = (sb < 0) ? -sb : sb;
        q = ma / mb;
        r = ma % mb;
        if ((sa < 0) != (sb < 0)) q = -q;
        if (sa < 0) r = -r;
        p = 64'(q); l = p[31:0];
        p = 64'(r); h = p[31:0];
      end
      default: begin l = a / b; h = a % b; end
    endcase
  endfunction

  // Model state: edge counter, the edge count at which the current op finishes,
  // and the result waiting for that edge.
  int          cyc = 0;
  int          done_cyc = 0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
  logic [31:0] p_hi = 32'd0, p_lo = 32'd0;
  bit          p_ok = 1'b0;

  function automatic bit m_busy();
    return cyc < done_cyc;
  endfunction

  always @(posedge clk) begin
    logic [31:0] th, tl;
    if (reset) begin
      m_hi = 32'd0; m_lo = 32'd0; p_ok = 1'b0; done_cyc = 0;
    end else if (m_busy()) begin
      if (cyc + 1 == done_cyc && p_ok) begin m_hi = p_hi; m_lo = p_lo; end
    end else if (md_en) begin
      if (md_op <= 3'd3) begin
        p_ok = !(md_op[1] && src_b == 32'd0);
        if (p_ok) begin ref_calc(md_op, src_a, src_b, th, tl); p_hi = th; p_lo = tl; end
        done_cyc = cyc + 1 + (md_op[1] ? DC : MC);
      end else if (md_op == 3'd6) m_hi = src_a;
      else if (md_op == 3'd7) m_lo = src_a;
    end
    cyc++;
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy",   {31'd0, busy},  {31'd0, m_busy()});
      chk("start",  {31'd0, start}, {31'd0, (md_en && md_op <= 3'd3 && !m_busy())});
      chk("hi",     hi, m_hi);
      chk("lo",     lo, m_lo);
      chk("md_out", md_out, (md_op == 3'd4) ? m_hi : m_lo);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc_wait(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    md_en = 1'b1; md_op = op; src_a = a; src_b = b;
    @(posedge clk); #1;
    md_en = 1'b0;
  endtask

  // Counts busy cycles until busy falls; leaves the bench in the cycle busy is low
  task automatic wait_idle(output int nbusy);
    nbusy = 0;
    while (busy && nbusy < 40) begin
      nbusy++;
      @(posedge clk); #1;
    end
    if (busy) chk("busy_timeout", 32'd1, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    logic [2:0] op;
    logic [31:0] a, b;

    reset = 1'b1;
    cyc_wait(3);
    reset = 1'b0;
    chk_en = 1'b1;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    // MULT -3 x 5
    drive(3'd0, 32'hFFFF_FFFD, 32'd5);
    wait_idle(n);
    chk("mult_busy_cycles", n, 32'd5);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFF1);

    // DIVU 100/7, HI/LO held mid-run
    drive(3'd3, 32'd100, 32'd7);
    cyc_wait(4);
    chk("divu_mid_lo", lo, 32'hFFFF_FFF1);
    wait_idle(n);
    chk("divu_busy_cycles", n + 4, 32'd10);
    chk("divu_lo", lo, 32'h0000_000E);
    chk("divu_hi", hi, 32'h0000_0002);

    // DIV -7/2 and MULTU max*max
    drive(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    drive(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle(n);
    chk("multu_hi", hi, 32'hFFFF_FFFE);
    chk("multu_lo", lo, 32'h0000_0001);

    // MTHI, then MFLO / MFHI reads, then divide by zero
    drive(3'd6, 32'h1234_5678, 32'd0);
    md_en = 1'b1; md_op = 3'd5; #1;
    chk("mflo", md_out, 32'h0000_0001);
    md_op = 3'd4; #1;
    chk("mfhi", md_out, 32'h1234_5678);
    md_en = 1'b0;
    drive(3'd2, 32'd55, 32'd0);
    wait_idle(n);
    chk("div0_busy_cycles", n, 32'd10);
    chk("div0_hi", hi, 32'h1234_5678);
    chk("div0_lo", lo, 32'h0000_0001);

    // Reset during the third busy cycle of a MULT
    drive(3'd0, 32'd7, 32'd9);
    cyc_wait(2);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    cyc_wait(8);
    chk("midrst_late_lo", lo, 32'd0);

    // MTLO while busy is ignored; back-to-back MULT on the cycle busy falls
    drive(3'd0, 32'd2, 32'd3);
    md_en = 1'b1; md_op = 3'd7; src_a = 32'h0000_AAAA; #1;
    chk("mtlo_busy_start", {31'd0, start}, 32'd0);
    @(posedge clk); #1;
    md_en = 1'b0;
    chk("mtlo_busy_lo", lo, 32'd0);
    wait_idle(n);
    chk("b2b_first_lo", lo, 32'd6);
    md_en = 1'b1; md_op = 3'd0; src_a = 32'd4; src_b = 32'd5; #1;
    chk("b2b_start", {31'd0, start}, 32'd1);
    @(posedge clk); #1;
    md_en = 1'b0;
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    wait_idle(n);
    chk("b2b_lo", lo, 32'd20);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      op = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 9));
        2: b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      if (op == 3'd2 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
      md_en = ($urandom_range(0, 9) < 7);
      md_op = op; src_a = a; src_b = b;
      reset = ($urandom_range(0, 149) == 0);
      @(posedge clk); #1;
    end
    reset = 1'b0;
    md_en = 1'b0;
    cyc_wait(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
